// File: rtl/serial_full_adder_if.sv
// serial_full_adder_if: request/response bundle for the bit-serial adder.
//   master : drives start/a/b/cin, observes busy/done/sum/cout(/ovf)
//   slave  : the adder itself
// The ovf signal exists only when SERIAL_FULL_ADDER_OVF_EN is defined.
interface serial_full_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_FULL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_FULL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_full_adder.sv
// serial_full_adder: LSB-first bit-serial adder, one full-adder cell plus a
// carry flop. Operands are captured on start while idle, one bit is added per
// clock, and {cout,sum} = a+b+cin is registered with a one-cycle done pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_full_adder_if.slave (start/a/b/cin in,
//                busy/done/sum/cout[/ovf] out)
// Optional: SERIAL_FULL_ADDER_OVF_EN adds a registered two's-complement
// overflow flag (carry into MSB xor carry out).

module serial_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_full_adder_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_s_q, sh_s_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;

  serial_full_adder_cell u_fa (
    .a  (sh_a_q[0]),
    .b  (sh_b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_a_d  = bus.a;
          sh_b_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_co;
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        // After WIDTH shifts the first sum bit has walked down to bit 0.
        sh_s_d  = {fa_s, sh_s_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = sh_s_d;
          cout_d  = fa_co;
`ifdef SERIAL_FULL_ADDER_OVF_EN
          // carry_q is the carry into the MSB during the final bit.
          ovf_d   = carry_q ^ fa_co;
`endif
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_FULL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_FULL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_FULL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder (WIDTH=8). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_serial_full_adder;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  serial_full_adder_if #(.WIDTH(W)) bus ();

  serial_full_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen; n = edges taken (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done !== 1'b1 && n < 30);
  endtask

  task automatic check_result(input string tag, input logic [7:0] s, input logic c,
                              input logic o);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum"},  32'(bus.sum),  32'(s));
    check({tag, "_cout"}, 32'(bus.cout), 32'(c));
`ifdef SERIAL_FULL_ADDER_OVF_EN
    check({tag, "_ovf"},  32'(bus.ovf),  32'(o));
`else
    if (o === 1'bx) $display("unused");
`endif
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] s, input logic c, input logic o);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = ci;
    tick();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check_result(tag, s, c, o);
    tick();
    check({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    check({tag, "_sum_hold"},  32'(bus.sum),  32'(s));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset held 3 cycles, idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_sum",  32'(bus.sum),  32'd0);
      check("rst_cout", 32'(bus.cout), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    run_op("v5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("vff00c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op("v7f7f", 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1);

    // Start while busy is ignored.
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.a = 8'h10;
    tick();
    bus.start = 1'b0;
    check("busy_sum_stable", 32'(bus.sum), 32'hFF);
    check("busy_still", 32'(bus.busy), 32'd1);
    wait_done(cyc);
    check("busy_latency", 32'(cyc), 32'd5);
    check_result("busy", 8'h02, 1'b0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) cyc++;
    end
    check("busy_no_2nd_done", 32'(cyc), 32'd0);

    // Asynchronous reset in the middle of an operation.
    bus.start = 1'b1; bus.a = 8'h7F; bus.b = 8'h01; bus.cin = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sum",  32'(bus.sum),  32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) cyc++;
    end
    check("mid_rst_no_done", 32'(cyc), 32'd0);
    run_op("v0304", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    // Back-to-back with start held high.
    bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b1;
    tick();
    wait_done(cyc);
    check("b2b0_latency", 32'(cyc), 32'd8);
    check_result("b2b0", 8'h01, 1'b1, 1'b1);
    for (int r = 1; r < 3; r++) begin
      wait_done(cyc);
      check("b2b_period", 32'(cyc), 32'd9);
      check_result("b2b", 8'h01, 1'b1, 1'b1);
    end
    bus.start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
